// File: rtl/multi_phase_generator_pkg.sv
// Shared constants and types for the multi-channel phase generator.
package multi_phase_gen_pkg;

    localparam int DEF_NUM_CHANNELS = 8;
    localparam int DEF_PHASE_WIDTH  = 7;
    localparam int DEF_STEP_DIV     = 10;
    localparam int DEF_ADDR_WIDTH   = 3;

    // Number of phase steps a channel stays high in each period.
    localparam int HALF_PERIOD = 2 ** (DEF_PHASE_WIDTH - 1);

    typedef logic [DEF_PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/phase_step_timer.sv
// Shared timebase: a prescaler that divides the system clock down to phase
// steps, and the free-running phase counter that all channels compare against.
module phase_step_timer
    import multi_phase_gen_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int STEP_DIV    = DEF_STEP_DIV
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic                   o_step_tick,
    output logic                   o_boundary,
    output logic [PHASE_WIDTH-1:0] o_phase_cnt
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PRE_W-1:0]       r_prescaler;
    logic [PHASE_WIDTH-1:0] r_phase_cnt;
    logic                   w_step_tick;

    assign w_step_tick = (r_prescaler == PRE_LAST);

    // Prescaler: 0..STEP_DIV-1, wrapping on the step tick.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prescaler <= '0;
        end else if (w_step_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    // Phase counter advances one step per tick and wraps naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase_cnt <= '0;
        end else if (w_step_tick) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    assign o_step_tick = w_step_tick;
    assign o_boundary  = w_step_tick && (&r_phase_cnt);
    assign o_phase_cnt = r_phase_cnt;

endmodule

// File: rtl/multi_phase_generator.sv
// N-channel square-wave generator with double-buffered phase offsets.
// Software loads shadow offsets at any time; an apply request commits all of
// them together on the next period boundary so every channel moves at once.
// apply_shift is a fire-and-forget request: apply_pending stays high from the
// cycle after the request until the commit edge, and update_done pulses for
// one cycle right after that edge.
module multi_phase_generator
    import multi_phase_gen_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int STEP_DIV     = DEF_STEP_DIV,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [PHASE_WIDTH-1:0]  wr_data,
    input  logic                    apply_shift,
    input  logic [NUM_CHANNELS-1:0] channel_enable,
    output logic [NUM_CHANNELS-1:0] clock_out,
    output logic                    apply_pending,
    output logic                    update_done,
    output logic                    period_start
);

    localparam logic [ADDR_WIDTH:0] NUM_CH_W = (ADDR_WIDTH + 1)'(NUM_CHANNELS);

    logic                    w_step_tick;
    logic                    w_boundary;
    logic [PHASE_WIDTH-1:0]  w_phase_cnt;
    logic                    w_commit;
    logic                    w_wr_hit;
    logic [NUM_CHANNELS-1:0] w_in_window;

    logic [PHASE_WIDTH-1:0]  r_shadow [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0]  r_active [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_en_active;
    logic [NUM_CHANNELS-1:0] r_clock_out;
    logic                    r_pending;
    logic                    r_update_done;
    logic                    r_period_start;
    logic                    r_step_start;

    phase_step_timer #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .STEP_DIV    (STEP_DIV)
    ) u_timer (
        .i_clk       (clock_in),
        .i_rst_n     (reset_n),
        .o_step_tick (w_step_tick),
        .o_boundary  (w_boundary),
        .o_phase_cnt (w_phase_cnt)
    );

    // A request arriving in the boundary cycle itself is committed immediately.
    assign w_commit = w_boundary && (r_pending || apply_shift);
    assign w_wr_hit = wr_en && ({1'b0, wr_addr} < NUM_CH_W);

    // Shadow offsets: written any time; out-of-range addresses are dropped.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    // Commit: copy the pre-edge shadows into the active set on the boundary.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_active[i] <= '0;
            end
            r_pending     <= 1'b0;
            r_update_done <= 1'b0;
        end else begin
            r_update_done <= w_commit;
            if (w_commit) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_pending <= 1'b0;
            end else if (apply_shift) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Enable mask only changes on period edges, so no runt pulses appear.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_en_active <= '0;
        end else if (w_boundary) begin
            r_en_active <= channel_enable;
        end
    end

    // A channel is high for the half period starting at its offset; the
    // modular difference is below half exactly when its top bit is clear.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        logic [PHASE_WIDTH-1:0] w_rel;
        assign w_rel           = w_phase_cnt - r_active[ch];
        assign w_in_window[ch] = ~w_rel[PHASE_WIDTH-1];
    end

    // Registered outputs, one cycle behind the phase counter.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_clock_out <= '0;
        end else begin
            r_clock_out <= r_en_active & w_in_window;
        end
    end

    // The prescaler sits at 0 right after reset and in the cycle after a tick.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_step_start <= 1'b1;
        end else begin
            r_step_start <= w_step_tick;
        end
    end

    // period_start marks the output cycle that reflects phase 0, prescaler 0.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= r_step_start && (w_phase_cnt == '0);
        end
    end

    assign clock_out     = r_clock_out;
    assign apply_pending = r_pending;
    assign update_done   = r_update_done;
    assign period_start  = r_period_start;

endmodule

// File: tb/tb_multi_phase_generator.sv
// Bench for multi_phase_generator: a time-domain reference model checked on
// every cycle, plus directed sequences measuring edge lags and pulse widths.
module tb_multi_phase_generator;
    import multi_phase_gen_pkg::*;

    localparam int NCH      = 8;
    localparam int PW       = 7;
    localparam int SDIV     = 10;
    localparam int AW       = 3;
    localparam int PERIOD   = (2 ** PW) * SDIV;
    localparam int HALF_CYC = HALF_PERIOD * SDIV;

    // ---------------- clock / reset / DUT ----------------
    logic           clock_in = 1'b0;
    logic           reset_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    phase_t         wr_data;
    logic           apply_shift;
    logic [NCH-1:0] channel_enable;
    logic [NCH-1:0] clock_out;
    logic           apply_pending;
    logic           update_done;
    logic           period_start;

    always #10 clock_in = ~clock_in;

    multi_phase_generator dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .apply_shift    (apply_shift),
        .channel_enable (channel_enable),
        .clock_out      (clock_out),
        .apply_pending  (apply_pending),
        .update_done    (update_done),
        .period_start   (period_start)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [NCH+2:0] exp_q[$];

    // Reference model: time since reset, offsets, enable mask, pending flag.
    int             m_cyc;
    phase_t         m_shadow [NCH];
    phase_t         m_active [NCH];
    logic [NCH-1:0] m_en;
    logic           m_pending;

    // Edge / run-length tracking on the observed outputs.
    logic [NCH-1:0] prev_clk;
    logic [NCH-1:0] rose;
    int             hi_start [NCH];
    int             lo_start [NCH];
    int             last_hi_len [NCH];
    int             last_lo_len [NCH];
    int             offs [NCH];
    int             done_count;

    typedef struct {
        int ch;
        int off;
        int exp_lag;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    // Model of one clock edge, using the inputs held before the edge. The
    // output is derived in the time domain: a channel is high for HALF_CYC
    // cycles starting offset*SDIV cycles into the period.
    task automatic model_edge();
        int   cp;
        int   d;
        bit   commit;
        logic [NCH-1:0] e_clk;
        logic e_ps;
        if (!reset_n) begin
            m_cyc     = 0;
            m_en      = '0;
            m_pending = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            exp_q.push_back('0);
        end else begin
            cp = m_cyc % PERIOD;
            for (int i = 0; i < NCH; i++) begin
                d = cp - int'(m_active[i]) * SDIV;
                if (d < 0) d += PERIOD;
                e_clk[i] = m_en[i] && (d < HALF_CYC);
            end
            e_ps   = (cp == 0);
            commit = 0;
            if (cp == PERIOD - 1) begin
                m_en = channel_enable;
                if (m_pending || apply_shift) commit = 1;
            end
            if (commit) begin
                for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0;
            end else if (apply_shift) begin
                m_pending = 1'b1;
            end
            if (wr_en && int'(wr_addr) < NCH) m_shadow[wr_addr] = wr_data;
            m_cyc++;
            exp_q.push_back({e_clk, m_pending, commit, e_ps});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [NCH+2:0] exp_w;
        logic [NCH+2:0] act_w;
        @(posedge clock_in);
        model_edge();
        #1;
        exp_w = exp_q.pop_front();
        act_w = {clock_out, apply_pending, update_done, period_start};
        n_checks++;
        if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL cycle_model at cycle %0d: got clk=%b pend=%b done=%b ps=%b, want clk=%b pend=%b done=%b ps=%b",
                     m_cyc, act_w[NCH+2:3], act_w[2], act_w[1], act_w[0],
                     exp_w[NCH+2:3], exp_w[2], exp_w[1], exp_w[0]);
        end
        rose = clock_out & ~prev_clk;
        for (int i = 0; i < NCH; i++) begin
            if (clock_out[i] && !prev_clk[i]) begin
                last_lo_len[i] = m_cyc - lo_start[i];
                hi_start[i]    = m_cyc;
            end else if (!clock_out[i] && prev_clk[i]) begin
                last_hi_len[i] = m_cyc - hi_start[i];
                lo_start[i]    = m_cyc;
            end
        end
        if (update_done) done_count++;
        prev_clk = clock_out;
    endtask

    task automatic write_ch(input int ch, input int val);
        wr_en   = 1'b1;
        wr_addr = AW'(ch);
        wr_data = PW'(val);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_apply();
        apply_shift = 1'b1;
        tick();
        apply_shift = 1'b0;
    endtask

    task automatic wait_period_start();
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!period_start && guard < PERIOD + 100);
        check("period_start_seen", int'(period_start), 1);
    endtask

    task automatic wait_commit();
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!update_done && guard < PERIOD + 100);
        check("commit_seen", int'(update_done), 1);
    endtask

    task automatic run_to_boundary();
        int guard = 0;
        while ((m_cyc % PERIOD) != PERIOD - 1 && guard < PERIOD + 10) begin
            tick();
            guard++;
        end
    endtask

    // Records, per channel, the last rising edge within one full period,
    // measured in cycles from the period_start pulse (-1 if none).
    task automatic measure();
        int p;
        for (int i = 0; i < NCH; i++) offs[i] = -1;
        wait_period_start();
        p = m_cyc;
        for (int i = 0; i < NCH; i++) if (rose[i]) offs[i] = 0;
        for (int k = 1; k < PERIOD; k++) begin
            tick();
            for (int i = 0; i < NCH; i++) if (rose[i]) offs[i] = m_cyc - p;
        end
    endtask

    initial begin
        #(2000000);
        $display("FAIL watchdog: time limit reached at cycle %0d", m_cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        tbl[0] = '{0,   0,    0};
        tbl[1] = '{1,   1,   10};
        tbl[2] = '{2,  63,  630};
        tbl[3] = '{3,  64,  640};
        tbl[4] = '{4, 127, 1270};
        tbl[5] = '{5,  31,  310};
        tbl[6] = '{6, 100, 1000};
        tbl[7] = '{7,  45,  450};

        reset_n        = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        apply_shift    = 1'b0;
        channel_enable = '1;
        prev_clk       = '0;
        rose           = '0;
        done_count     = 0;
        m_cyc          = 0;
        for (int i = 0; i < NCH; i++) begin
            hi_start[i] = 0; lo_start[i] = 0;
            last_hi_len[i] = 0; last_lo_len[i] = 0;
        end

        repeat (3) tick();
        check("reset_clock_out", int'(clock_out), 0);
        check("reset_pending", int'(apply_pending), 0);
        check("reset_done", int'(update_done), 0);
        check("reset_period_start", int'(period_start), 0);
        reset_n = 1'b1;

        // Quiet first period, then all channels aligned with 50% duty.
        measure();
        for (int i = 0; i < NCH; i++) check("first_period_quiet", offs[i], -1);
        measure();
        for (int i = 0; i < NCH; i++) check("aligned_start", offs[i], 0);
        tick();
        check("high_len_ch0", last_hi_len[0], HALF_CYC);
        check("low_len_ch0", last_lo_len[0], HALF_CYC);

        // ch1 = 15 applied at cycle 5000.
        write_ch(1, 15);
        while (m_cyc < 5000) tick();
        d0 = done_count;
        pulse_apply();
        check("pending_after_apply", int'(apply_pending), 1);
        wait_commit();
        check("commit_cycle", m_cyc, 5120);
        tick();
        check("done_single", done_count - d0, 1);
        check("pending_cleared", int'(apply_pending), 0);
        measure();
        check("ch0_at_start", offs[0], 0);
        check("lag_ch1", offs[1] - offs[0], 150);

        // Latest shadow value before the boundary wins.
        write_ch(3, 64);
        pulse_apply();
        write_ch(3, 32);
        wait_commit();
        measure();
        check("lag_ch3_latest_shadow", offs[3] - offs[0], 320);

        // Apply and write coincide with the boundary.
        write_ch(2, 20);
        run_to_boundary();
        apply_shift = 1'b1;
        wr_en       = 1'b1;
        wr_addr     = AW'(2);
        wr_data     = PW'(100);
        tick();
        apply_shift = 1'b0;
        wr_en       = 1'b0;
        check("boundary_commit_done", int'(update_done), 1);
        tick();
        check("boundary_apply_consumed", int'(apply_pending), 0);
        measure();
        check("lag_ch2_old_shadow", offs[2] - offs[0], 200);
        pulse_apply();
        wait_commit();
        measure();
        check("lag_ch2_new_shadow", offs[2] - offs[0], 1000);

        // Disable ch5 in the middle of its high phase.
        wait_period_start();
        repeat (300) tick();
        channel_enable[5] = 1'b0;
        tick();
        check("ch5_holds_mid_high", int'(clock_out[5]), 1);
        measure();
        check("ch5_full_high", last_hi_len[5], HALF_CYC);
        check("ch5_stopped", offs[5], -1);
        check("ch4_running", offs[4], 0);
        channel_enable = '1;

        // Reset while a commit is pending.
        write_ch(6, 50);
        pulse_apply();
        check("pending_before_reset", int'(apply_pending), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midreset_clock_out", int'(clock_out), 0);
        check("midreset_pending", int'(apply_pending), 0);
        d0 = done_count;
        measure();
        check("post_reset_quiet_ch6", offs[6], -1);
        measure();
        check("no_stale_commit_ch6", offs[6], 0);
        check("no_stale_commit_ch1", offs[1], 0);
        check("no_commit_after_reset", done_count - d0, 0);

        // Table of offsets across all channels.
        for (int v = 0; v < 8; v++) write_ch(tbl[v].ch, tbl[v].off);
        pulse_apply();
        wait_commit();
        measure();
        for (int v = 0; v < 8; v++) check($sformatf("table_lag_ch%0d", tbl[v].ch), offs[tbl[v].ch], tbl[v].exp_lag);

        // Random traffic against the reference model.
        repeat (8 * PERIOD) begin
            wr_en       = ($urandom_range(0, 49) == 0);
            wr_addr     = AW'($urandom_range(0, 7));
            wr_data     = PW'($urandom_range(0, 127));
            apply_shift = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) channel_enable = NCH'($urandom_range(0, 255));
            tick();
        end
        wr_en       = 1'b0;
        apply_shift = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_phase_generator.md
Name: multi_phase_generator

Overview:
- N-channel square-wave phase generator for the transducer array: one shared period counter and an independent programmable phase offset per channel.
- Supersedes the single-channel phase_generator.
- Phase offsets are double-buffered. Software writes shadow registers, then an apply strobe commits all channels together at the next period boundary, so every channel switches in the same cycle.
- Runs directly on the 50 MHz system clock. An internal prescaler replaces the external clock_divider.

Parameters:
- NUM_CHANNELS, 8, number of output channels.
- PHASE_WIDTH, 7, phase resolution in bits; the period is 2**PHASE_WIDTH steps.
- STEP_DIV, 10, clock_in cycles per phase step. Default period is 1280 cycles, about 39.06 kHz at 50 MHz.
- ADDR_WIDTH, 3, channel-address width; must satisfy 2**ADDR_WIDTH >= NUM_CHANNELS.

Ports:
- clock_in  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous, active-low reset.
- wr_en  input  1  write strobe for a shadow phase register.
- wr_addr  input  ADDR_WIDTH  channel index for the write.
- wr_data  input  PHASE_WIDTH  phase offset in steps.
- apply_shift  input  1  request to commit all shadow phases at the next period boundary.
- channel_enable  input  NUM_CHANNELS  per-channel output enable, sampled at period boundaries.
- clock_out  output  NUM_CHANNELS  phase-shifted square waves.
- apply_pending  output  1  high while a commit is requested but not yet done.
- update_done  output  1  one-cycle pulse in the cycle after the commit.
- period_start  output  1  one-cycle pulse aligned with phase_cnt==0.

Behaviour:
- Reset (reset_n low at a clock edge) clears everything to 0:
  - prescaler, phase_cnt, all shadow and active phases, active enable mask;
  - apply_pending, update_done, period_start, clock_out.
- Reset mid-operation abandons any pending commit.
- Prescaler:
  - counts 0..STEP_DIV-1, then wraps;
  - step_tick = (prescaler==STEP_DIV-1).
- phase_cnt (PHASE_WIDTH bits):
  - increments on step_tick and wraps naturally from 2**PHASE_WIDTH-1 to 0;
  - boundary = step_tick && phase_cnt==all-ones.
- Shadow write:
  - when wr_en is high and wr_addr < NUM_CHANNELS, shadow[wr_addr] <= wr_data on the next edge;
  - out-of-range addresses are ignored silently;
  - writes are accepted at any time, including while a commit is pending. The value held at the boundary edge is the one committed.
- Apply:
  - pending_q sets on apply_shift and clears on the commit edge;
  - apply_pending = pending_q;
  - on boundary, if pending_q or apply_shift is high, every active[i] <= shadow[i] (pre-edge shadow value);
  - a wr_en in the same cycle as the commit lands in shadow only and is not committed;
  - an apply_shift in the same cycle as the commit is consumed by that commit, and pending_q stays 0;
  - repeated apply_shift while pending has no additional effect.
- update_done: pulses for exactly one cycle in the cycle after a commit edge.
- Enable mask: on every boundary, en_active <= channel_enable, regardless of apply. Channels therefore start and stop only on period edges, so there are no runt pulses.
- Output, registered with 1-cycle latency from phase_cnt:
  - clock_out[i] <= en_active[i] && ((phase_cnt - active[i]) mod 2**PHASE_WIDTH) < 2**(PHASE_WIDTH-1);
  - 50 % duty; the channel goes high when phase_cnt equals active[i];
  - a larger offset gives a later edge;
  - the subtraction is PHASE_WIDTH-bit modular arithmetic.
- period_start: registered pulse, high for the single cycle in which the registered output reflects phase_cnt==0 with the prescaler at 0.
- After reset: outputs stay 0 until the first boundary at cycle 1279, even if channel_enable is all ones.

Decomposition:
- Package multi_phase_gen_pkg holds:
  - default PHASE_WIDTH, STEP_DIV and NUM_CHANNELS constants;
  - HALF_PERIOD = 2**(PHASE_WIDTH-1);
  - a phase_t typedef of PHASE_WIDTH bits.
- Sub-module phase_step_timer holds the prescaler and phase_cnt, and outputs step_tick, boundary and phase_cnt.
- The per-channel compare is a generate loop in the top module.

Test Plan:
- Reset, channel_enable=all ones, no writes -> clock_out=0 through cycle 1280. Then all channels are identical: high 640 cycles, low 640 cycles, repeating.
- Write ch0=0 and ch1=15, apply_shift pulsed 1 cycle at cycle 5000 -> apply_pending high until the next boundary. update_done pulses once. ch1 rising edge lags ch0 by exactly 150 cycles thereafter.
- Write ch3=64, apply, then ch3=32 before the boundary -> the committed lag is 320 cycles, not 640.
- apply_shift and wr_en(ch2=100) in the same cycle as the boundary -> the commit uses the old ch2 shadow. apply_pending stays 0 afterwards. A second apply commits 100, giving a lag of 1000 cycles.
- Deassert channel_enable[5] mid-high-phase -> ch5 drops only 1 cycle after the next boundary. No pulse shorter than 640 cycles appears.
- Assert reset_n low for 1 cycle during a pending apply -> all outputs 0, apply_pending 0, and the old shadow values are not committed.
